// File: rtl/echo_param_ctrl.sv
// Echo parameter sequencer.
// Takes delay/alpha change requests and applies them to the Echo datapath
// without clicks: alpha fades to zero, the delay line is allowed to drain,
// the delay switches, then alpha fades to its new target. All output
// movement happens on audio sample strobes.
//
// Handshake: a request transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high only while the sequencer is
// idle. The requester holds cfg_valid and the cfg_* fields stable until
// the transfer. A cfg_valid seen while busy is neither accepted nor queued.
module echo_param_ctrl #(
  parameter int                 DELAY_W       = 16,
  parameter int                 ALPHA_W       = 16,
  parameter int                 MAX_DELAY     = 16383,
  parameter int                 DEFAULT_DELAY = 10000,
  parameter logic [ALPHA_W-1:0] DEFAULT_ALPHA = 16'h7FFF,
  parameter logic [ALPHA_W-1:0] RAMP_STEP     = 16'h0100,
  parameter int                 FLUSH_SAMPLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [ALPHA_W-1:0] cfg_alpha,
  output logic [DELAY_W-1:0] delay_time,
  output logic [ALPHA_W-1:0] alpha_sth,
  output logic               busy,
  output logic               cfg_err,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_DOWN = 3'd1,
    S_FLUSH     = 3'd2,
    S_SWITCH    = 3'd3,
    S_RAMP_TGT  = 3'd4
  } state_t;

  localparam int CNT_W = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
  localparam logic [DELAY_W-1:0] MAX_D     = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] DEF_D     = DELAY_W'(DEFAULT_DELAY);
  localparam logic [DELAY_W-1:0] MIN_D     = DELAY_W'(1);
  localparam logic [CNT_W-1:0]   FLUSH_END = CNT_W'(FLUSH_SAMPLES - 1);

  state_t               state_q, state_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [ALPHA_W-1:0]   alpha_q, alpha_d;
  logic [DELAY_W-1:0]   pend_delay_q, pend_delay_d;
  logic [ALPHA_W-1:0]   pend_alpha_q, pend_alpha_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                 err_q, err_d;

  // Request after clamping into the legal range.
  logic [DELAY_W-1:0]   req_delay;
  logic [ALPHA_W-1:0]   req_alpha;
  logic                 req_clamped;

  // Alpha arithmetic is one bit wider than the port so a step can never wrap.
  logic signed [ALPHA_W:0] a_ext;
  logic signed [ALPHA_W:0] t_ext;
  logic signed [ALPHA_W:0] step_ext;
  logic signed [ALPHA_W:0] down_raw;
  logic signed [ALPHA_W:0] down_sat;
  logic signed [ALPHA_W:0] up_raw;
  logic signed [ALPHA_W:0] up_lim;
  logic signed [ALPHA_W:0] dn_lim;
  logic signed [ALPHA_W:0] toward;

  // Clamp the incoming request and flag whether anything was changed.
  always_comb begin
    req_delay   = cfg_delay;
    req_alpha   = cfg_alpha;
    req_clamped = 1'b0;
    if (cfg_delay > MAX_D) begin
      req_delay   = MAX_D;
      req_clamped = 1'b1;
    end else if (cfg_delay == '0) begin
      req_delay   = MIN_D;
      req_clamped = 1'b1;
    end
    if (cfg_alpha[ALPHA_W-1]) begin
      req_alpha   = '0;
      req_clamped = 1'b1;
    end
  end

  // Candidate alpha values for one ramp step, each limited so it lands on its bound.
  always_comb begin
    a_ext    = {alpha_q[ALPHA_W-1], alpha_q};
    t_ext    = {pend_alpha_q[ALPHA_W-1], pend_alpha_q};
    step_ext = {1'b0, RAMP_STEP};
    down_raw = a_ext - step_ext;
    down_sat = down_raw[ALPHA_W] ? '0 : down_raw;
    up_raw   = a_ext + step_ext;
    up_lim   = (up_raw > t_ext) ? t_ext : up_raw;
    dn_lim   = (down_raw < t_ext) ? t_ext : down_raw;
    toward   = (a_ext < t_ext) ? up_lim : dn_lim;
  end

  // Next-state and datapath update; nothing but request capture moves without sample_en.
  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    alpha_d      = alpha_q;
    pend_delay_d = pend_delay_q;
    pend_alpha_d = pend_alpha_q;
    flush_cnt_d  = flush_cnt_q;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          pend_delay_d = req_delay;
          pend_alpha_d = req_alpha;
          err_d        = req_clamped;
          flush_cnt_d  = '0;
          state_d      = (req_delay == delay_q) ? S_RAMP_TGT : S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (sample_en) begin
          alpha_d = down_sat[ALPHA_W-1:0];
          if (down_sat == '0) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (sample_en) begin
          if (flush_cnt_q == FLUSH_END) begin
            flush_cnt_d = '0;
            state_d     = S_SWITCH;
          end else begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
          end
        end
      end
      S_SWITCH: begin
        if (sample_en) begin
          delay_d = pend_delay_q;
          state_d = S_RAMP_TGT;
        end
      end
      S_RAMP_TGT: begin
        if (sample_en) begin
          if (a_ext == t_ext) begin
            state_d = S_IDLE;
          end else begin
            alpha_d = toward[ALPHA_W-1:0];
            if (toward == t_ext) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      delay_q      <= DEF_D;
      alpha_q      <= DEFAULT_ALPHA;
      pend_delay_q <= DEF_D;
      pend_alpha_q <= DEFAULT_ALPHA;
      flush_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      alpha_q      <= alpha_d;
      pend_delay_q <= pend_delay_d;
      pend_alpha_q <= pend_alpha_d;
      flush_cnt_q  <= flush_cnt_d;
      err_q        <= err_d;
    end
  end

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign delay_time = delay_q;
  assign alpha_sth  = alpha_q;
  assign cfg_err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_echo_param_ctrl.sv
// Directed bench for echo_param_ctrl: reset, alpha-only and delay changes,
// clamping, busy blocking and reset in the middle of a ramp.
module tb_echo_param_ctrl;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_alpha;
  logic [15:0] delay_time;
  logic [15:0] alpha_sth;
  logic        busy;
  logic        cfg_err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] ea;

  echo_param_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_delay  (cfg_delay),
    .cfg_alpha  (cfg_alpha),
    .delay_time (delay_time),
    .alpha_sth  (alpha_sth),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (caller ensures the controller is idle).
  task automatic send_cfg(input logic [15:0] d, input logic [15:0] a);
    cfg_valid = 1'b1;
    cfg_delay = d;
    cfg_alpha = a;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // One sample strobe, then gap idle clocks; outputs must match and hold.
  task automatic step(input int gap, input logic [15:0] exp_a, input logic [15:0] exp_d,
                      input string tag);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    chk({tag, "_alpha"}, 32'(alpha_sth), 32'(exp_a));
    chk({tag, "_delay"}, 32'(delay_time), 32'(exp_d));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk({tag, "_hold_alpha"}, 32'(alpha_sth), 32'(exp_a));
      chk({tag, "_hold_delay"}, 32'(delay_time), 32'(exp_d));
    end
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; cfg_valid = 1'b0; cfg_delay = '0; cfg_alpha = '0;

    // T1 reset values
    repeat (3) @(negedge clk);
    chk("rst_delay", 32'(delay_time), 32'd10000);
    chk("rst_alpha", 32'(alpha_sth), 32'h7FFF);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(cfg_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T2 alpha-only change 0x7FFF -> 0x4000, strobe every 4 clocks
    send_cfg(16'd10000, 16'h4000);
    chk("t2_ready", 32'(cfg_ready), 32'd0);
    chk("t2_busy",  32'(busy), 32'd1);
    chk("t2_err",   32'(cfg_err), 32'd0);
    chk("t2_alpha0", 32'(alpha_sth), 32'h7FFF);
    for (int k = 1; k <= 64; k++) begin
      ea = (k == 64) ? 16'h4000 : 16'(32'h7FFF - k * 256);
      step(3, ea, 16'd10000, "t2");
    end
    chk("t2_done_busy",  32'(busy), 32'd0);
    chk("t2_done_ready", 32'(cfg_ready), 32'd1);

    // T6 reset in the middle of a ramp down at alpha 0x3000
    send_cfg(16'd5000, 16'h7FFF);
    for (int k = 1; k <= 16; k++) begin
      ea = 16'(32'h4000 - k * 256);
      step(1, ea, 16'd10000, "t6");
    end
    chk("t6_mid_alpha", 32'(alpha_sth), 32'h3000);
    chk("t6_mid_busy",  32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_alpha", 32'(alpha_sth), 32'h7FFF);
    chk("t6_rst_delay", 32'(delay_time), 32'd10000);
    chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
    chk("t6_rst_busy",  32'(busy), 32'd0);
    chk("t6_rst_err",   32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 16'h7FFF, 16'd10000, "t6_after");
    chk("t6_after_busy", 32'(busy), 32'd0);
    chk("t6_after_err",  32'(cfg_err), 32'd0);

    // T3 delay change 10000 -> 5000, sample_en back to back
    send_cfg(16'd5000, 16'h7FFF);
    chk("t3_err", 32'(cfg_err), 32'd0);
    for (int k = 1; k <= 128; k++) begin
      ea = (k == 128) ? 16'h0000 : 16'(32'h7FFF - k * 256);
      step(0, ea, 16'd10000, "t3_down");
    end
    for (int k = 1; k <= 16; k++) step(0, 16'h0000, 16'd10000, "t3_flush");
    chk("t3_flush_busy", 32'(busy), 32'd1);
    step(0, 16'h0000, 16'd5000, "t3_switch");
    for (int k = 1; k <= 128; k++) begin
      ea = (k == 128) ? 16'h7FFF : 16'(k * 256);
      step(0, ea, 16'd5000, "t3_up");
    end
    chk("t3_done_busy",  32'(busy), 32'd0);
    chk("t3_done_ready", 32'(cfg_ready), 32'd1);

    // T4 clamp: delay too large and negative alpha
    send_cfg(16'd20000, 16'h8000);
    chk("t4_err_pulse", 32'(cfg_err), 32'd1);
    chk("t4_busy",      32'(busy), 32'd1);
    @(negedge clk);
    chk("t4_err_low",   32'(cfg_err), 32'd0);
    chk("t4_alpha_hold", 32'(alpha_sth), 32'h7FFF);
    for (int k = 1; k <= 128; k++) begin
      ea = (k == 128) ? 16'h0000 : 16'(32'h7FFF - k * 256);
      step(1, ea, 16'd5000, "t4_down");
    end
    for (int k = 1; k <= 16; k++) step(1, 16'h0000, 16'd5000, "t4_flush");
    step(1, 16'h0000, 16'd16383, "t4_switch");
    chk("t4_tgt_busy", 32'(busy), 32'd1);
    step(1, 16'h0000, 16'd16383, "t4_tgt");
    chk("t4_done_busy", 32'(busy), 32'd0);

    // T7 zero delay clamps to 1
    send_cfg(16'd16383, 16'h0200);
    chk("t7a_err", 32'(cfg_err), 32'd0);
    step(1, 16'h0100, 16'd16383, "t7a");
    step(1, 16'h0200, 16'd16383, "t7a");
    chk("t7a_busy", 32'(busy), 32'd0);
    send_cfg(16'd0, 16'h0200);
    chk("t7_err", 32'(cfg_err), 32'd1);
    step(1, 16'h0100, 16'd16383, "t7_down");
    step(1, 16'h0000, 16'd16383, "t7_down");
    for (int k = 1; k <= 16; k++) step(1, 16'h0000, 16'd16383, "t7_flush");
    step(1, 16'h0000, 16'd1, "t7_switch");
    step(1, 16'h0100, 16'd1, "t7_up");
    step(1, 16'h0200, 16'd1, "t7_up");
    chk("t7_busy", 32'(busy), 32'd0);

    // T8 request equal to current settings: one strobe, no step
    send_cfg(16'd1, 16'h0200);
    chk("t8_err",  32'(cfg_err), 32'd0);
    chk("t8_busy", 32'(busy), 32'd1);
    step(1, 16'h0200, 16'd1, "t8");
    chk("t8_done_busy", 32'(busy), 32'd0);

    // T5 new request held while busy is not taken until idle
    send_cfg(16'd1, 16'h7FFF);
    cfg_valid = 1'b1;
    cfg_delay = 16'd1;
    cfg_alpha = 16'h1000;
    for (int k = 1; k <= 126; k++) begin
      ea = (k == 126) ? 16'h7FFF : 16'(32'h0200 + k * 256);
      step(0, ea, 16'd1, "t5_up");
      if (k == 60) chk("t5_ready_busy", 32'(cfg_ready), 32'd0);
    end
    chk("t5_idle_busy",  32'(busy), 32'd0);
    chk("t5_idle_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("t5_acc_busy",  32'(busy), 32'd1);
    chk("t5_acc_ready", 32'(cfg_ready), 32'd0);
    chk("t5_acc_alpha", 32'(alpha_sth), 32'h7FFF);
    for (int k = 1; k <= 112; k++) begin
      ea = (k == 112) ? 16'h1000 : 16'(32'h7FFF - k * 256);
      step(2, ea, 16'd1, "t5_down");
    end
    chk("t5_done_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
